// File: rtl/cnt_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cnt_sequencer
//  Purpose  : Command sequencer for a 16-bit up/down counter: load, verify,
//             count to target, report done/err.
//  Revision : 1.0  initial release
// ============================================================================
module cnt_sequencer #(
  parameter int WIDTH       = 16,
  parameter int WDOG_CYCLES = 65540
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic             cmd_dir,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             ld_cnt,
  output logic             updn_cnt,
  output logic             count_enb,
  output logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int                WDOG_W     = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_CYCLES);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_VERIFY = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  logic [2:0]        state_q,   state_d;
  logic [WIDTH-1:0]  start_q,   start_d;
  logic [WIDTH-1:0]  target_q,  target_d;
  logic              dir_q,     dir_d;
  logic [WDOG_W-1:0] wdog_q,    wdog_d;
  logic              ld_cnt_q,  ld_cnt_d;
  logic              updn_q,    updn_d;
  logic [WIDTH-1:0]  data_in_q, data_in_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic              err_q,     err_d;
  logic              ready_q,   ready_d;

  logic              at_target;
  logic [WIDTH-1:0]  next_value;
  logic              run_enb;
  logic [WDOG_W-1:0] wdog_inc;

  assign at_target  = (cnt_value == target_q);
  assign next_value = dir_q ? (cnt_value + WIDTH'(1)) : (cnt_value - WIDTH'(1));
  assign wdog_inc   = wdog_q + WDOG_W'(1);
  // Enable is combinational from cnt_value so the counter stops exactly on
  // target; abort and reset cut it in the same cycle.
  assign run_enb    = (state_q == S_RUN) && !at_target && !abort && !rst;

  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    target_d  = target_q;
    dir_d     = dir_q;
    wdog_d    = wdog_q;
    data_in_d = data_in_q;
    updn_d    = updn_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          state_d   = S_LOAD;
          start_d   = cmd_start;
          target_d  = cmd_target;
          dir_d     = cmd_dir;
          data_in_d = cmd_start;
          updn_d    = cmd_dir;
        end
      end
      S_LOAD: begin
        state_d = abort ? S_ERR : S_VERIFY;
      end
      S_VERIFY: begin
        if (abort || (cnt_value != start_q)) begin
          state_d = S_ERR;
        end else if (start_q == target_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
          wdog_d  = '0;
        end
      end
      S_RUN: begin
        wdog_d = wdog_inc;
        // Completion is taken on the last enabled cycle so done follows it directly.
        if (at_target || (run_enb && (next_value == target_q))) begin
          state_d = S_DONE;
        end else if (abort || (wdog_inc == WDOG_LIMIT)) begin
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ld_cnt_d = (state_d != S_LOAD);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    err_d    = (state_d == S_ERR);
    ready_d  = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      start_q   <= '0;
      target_q  <= '0;
      dir_q     <= 1'b0;
      wdog_q    <= '0;
      ld_cnt_q  <= 1'b1;
      updn_q    <= 1'b1;
      data_in_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      target_q  <= target_d;
      dir_q     <= dir_d;
      wdog_q    <= wdog_d;
      ld_cnt_q  <= ld_cnt_d;
      updn_q    <= updn_d;
      data_in_q <= data_in_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign ld_cnt    = ld_cnt_q;
  assign updn_cnt  = updn_q;
  assign count_enb = run_enb;
  assign data_in   = data_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: doc/cnt_sequencer.md
Name: cnt_sequencer

Overview:
- Control stage directly upstream of the 16-bit up/down counter.
- Accepts a count command {start, target, direction} over a valid/ready handshake.
- Drives the counter's ld_cnt, updn_cnt, count_enb and data_in. Watches the counter's data_out to stop it exactly at target.
- Reports completion with a done pulse, and reports load-verify failures or watchdog expiry with an error pulse.

Parameters:
- WIDTH, 16, counter data width; sets the width of cmd_start, cmd_target, data_in and cnt_value.
- WDOG_CYCLES, 65540, maximum cycles allowed in RUN before the command is aborted with an error. Watchdog counter width is $clog2(WDOG_CYCLES+1).

Ports:
- clk  in  1  rising-edge clock, shared with the counter.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE).
- cmd_start  in  WIDTH  value loaded into the counter.
- cmd_target  in  WIDTH  value at which counting stops.
- cmd_dir  in  1  1 = count up, 0 = count down.
- abort  in  1  cancel the active command.
- cnt_value  in  WIDTH  counter data_out, fed back.
- ld_cnt  out  1  counter load strobe, active-low (0 = load data_in on next edge).
- updn_cnt  out  1  counter direction (1 = up).
- count_enb  out  1  counter enable, active-high.
- data_in  out  WIDTH  counter load value.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: counter reached target.
- err  out  1  one-cycle pulse: verify mismatch, watchdog expiry, or abort.

Behaviour:
- Reset (sync, rst=1 at a clk edge) sets:
  - state = IDLE; ld_cnt = 1; count_enb = 0; updn_cnt = 1; data_in = 0.
  - busy = 0; done = 0; err = 0; cmd_ready = 1 after the reset cycle.
  - Command registers and watchdog are cleared.
- Reset mid-operation:
  - Same result; the command is dropped and no done or err pulse is issued.
  - Counter contents are left as-is.
- Handshake:
  - Accept happens on a clk edge with cmd_valid=1 and cmd_ready=1.
  - On accept, cmd_start, cmd_target and cmd_dir are registered.
  - cmd_ready is a registered output, high only in IDLE. Command inputs are ignored elsewhere.
- FSM states IDLE, LOAD, VERIFY, RUN, DONE, ERR:
  - IDLE -> LOAD on accept.
  - LOAD, exactly 1 cycle:
    - ld_cnt = 0, data_in = start, updn_cnt = dir, count_enb = 0.
    - Next state is VERIFY.
  - VERIFY, 1 cycle:
    - ld_cnt = 1, count_enb = 0.
    - If cnt_value != start -> ERR.
    - Else if start == target -> DONE.
    - Else -> RUN, with the watchdog cleared.
  - RUN:
    - count_enb = (cnt_value != target). This is combinational from cnt_value, so the counter never overshoots.
    - updn_cnt holds dir. The watchdog increments each cycle.
    - When cnt_value == target -> DONE.
    - When the watchdog reaches WDOG_CYCLES -> ERR.
    - When abort=1 -> ERR, with count_enb forced to 0 in that same cycle.
  - DONE: done=1 for one cycle, then IDLE.
  - ERR: err=1 for one cycle, then IDLE.
- Simultaneous events in RUN:
  - Target reached together with watchdog expiry gives DONE.
  - Abort together with target reached gives DONE; target wins over abort.
  - abort has no effect outside LOAD, VERIFY and RUN. In LOAD or VERIFY it forces ERR on the next edge.
- Wrap-around is legal:
  - Up count from start to target takes (target - start) mod 2^WIDTH enabled cycles.
  - Down count takes (start - target) mod 2^WIDTH enabled cycles.
- All outputs except count_enb are registered.
- data_in holds its last loaded value outside LOAD.
- Latency: accept to first count_enb=1 is 2 cycles (LOAD, VERIFY). Last count_enb=1 to done=1 is 1 cycle.

Test Plan:
- Up count: start=5, target=8, dir=1.
  - Expect ld_cnt=0 for exactly 1 cycle with data_in=5, then count_enb=1 for 3 cycles.
  - Expect done pulse 1 cycle later, cnt_value stable at 8, cmd_ready back high.
- Down count: start=10, target=7, dir=0.
  - Expect updn_cnt=0, 3 enabled cycles, done=1, cnt_value=7.
- Wrap: start=0xFFFE, target=0x0001, dir=1.
  - Expect count_enb high 3 cycles (0xFFFE, 0xFFFF, 0x0000 observed), done, final value 0x0001.
- Zero length: start=target=0x1234.
  - Expect LOAD, VERIFY, done with count_enb never asserted.
- Fault: force cnt_value stuck at 0 with start=5.
  - Expect err pulse after VERIFY and no done.
- Separately, pulse abort in RUN after 2 counts of 5->20.
  - Expect count_enb drops that cycle, err=1, counter holds at 7.
- Reset: assert rst during RUN of 0->100 at value 40.
  - Expect count_enb=0 and state IDLE on the next edge, no done or err pulse, cnt_value held at 40.
  - A new command 40->42 then completes normally.
